// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: bundles the uart byte handshake, cpu bus and ram port
// of uart_boot_loader.
//   rx_data/rx_done  received byte and its one-clk strobe
//   tx_data/tx_wr    ACK/NAK byte and its one-clk transmit strobe
//   tx_done          one-clk pulse when the transmit completes
//   cpu_addr/we/do   cpu ram bus (only [12:0] of the address reaches ram)
//   cpu_rst          active-low cpu reset
//   ram_addr/we/di   shared ram write port
//   busy             high while the loader owns the ram port
// Modports: slave = the loader, master = the surrounding system / bench.
interface uart_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_done;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic        cpu_rst;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic        busy;

  modport slave (
    input  rx_data, rx_done, tx_done, cpu_addr, cpu_we, cpu_do,
    output tx_data, tx_wr, cpu_rst, ram_addr, ram_we, ram_di, busy
  );

  modport master (
    output rx_data, rx_done, tx_done, cpu_addr, cpu_we, cpu_do,
    input  tx_data, tx_wr, cpu_rst, ram_addr, ram_we, ram_di, busy
  );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: boot-time ram loader and ram-port arbiter.
// After reset the cpu is held in reset while a frame
//   SYNC LEN_H LEN_L ADR_H ADR_L DATA[len] CSUM
// is received over the uart and its payload is written to the 8 KiB ram at
// (base + offset) mod 8192. A matching 8-bit checksum releases the cpu and
// hands it the ram port; a mismatch returns to waiting for a new frame. If no
// sync byte arrives within BOOT_TIMEOUT cycles the cpu runs from existing ram.
// Ports:
//   clk  system / cpu / ram clock
//   rst  asynchronous active-low reset
//   bus  uart_boot_loader_if.slave (uart bytes, cpu bus, ram port, busy)
// Build option:
//   UART_BOOT_LOADER_ACK_EN  when defined, an ACK (06) / NAK (15) byte is sent
//                            after the checksum and tx_done is awaited before
//                            the next state; otherwise tx_wr/tx_data stay 0.
module uart_boot_loader #(
  parameter int unsigned BOOT_TIMEOUT = 50000000,
  parameter int unsigned BYTE_TIMEOUT = 1000000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  uart_boot_loader_if.slave bus
);
  localparam int unsigned TMAX  = (BOOT_TIMEOUT > BYTE_TIMEOUT) ? BOOT_TIMEOUT : BYTE_TIMEOUT;
  localparam int          TMR_W = $clog2(TMAX + 1);
  // Timeouts fire when the counter sits at the parameter value minus one.
  localparam logic [TMR_W-1:0] BOOT_LAST = TMR_W'(BOOT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BYTE_LAST = TMR_W'(BYTE_TIMEOUT - 1);

`ifdef UART_BOOT_LOADER_ACK_EN
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [3:0] {
    WAIT_SYNC, LEN_H, LEN_L, ADR_H, ADR_L, DATA, CSUM, ACK, RUN
  } state_t;
`else
  typedef enum logic [3:0] {
    WAIT_SYNC, LEN_H, LEN_L, ADR_H, ADR_L, DATA, CSUM, RUN
  } state_t;
`endif

  typedef struct packed {
    logic [12:0] addr;
    logic        we;
    logic [7:0]  di;
  } ram_req_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;      // boot timer in WAIT_SYNC, inter-byte timer in a frame
  logic [15:0]      len_q;
  logic [15:0]      off_q;
  logic [12:0]      base_q;
  logic [7:0]       csum_q;
  ram_req_t         ldr_q;    // loader's registered ram write
  ram_req_t         cpu_req;
  ram_req_t         ram_sel;
  logic             cpu_rst_q;
  logic             busy_q;
  logic             csum_ok;

`ifdef UART_BOOT_LOADER_ACK_EN
  logic             tx_wr_q;
  logic [7:0]       tx_data_q;
  logic             tgt_run_q;  // where ACK goes once tx_done arrives
`endif

  assign csum_ok = (bus.rx_data == csum_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_SYNC;
      tmr       <= '0;
      len_q     <= '0;
      off_q     <= '0;
      base_q    <= '0;
      csum_q    <= '0;
      ldr_q     <= '0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b1;
`ifdef UART_BOOT_LOADER_ACK_EN
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      tgt_run_q <= 1'b0;
`endif
    end else begin
      // Write enable and transmit strobe are single-cycle pulses.
      ldr_q.we <= 1'b0;
`ifdef UART_BOOT_LOADER_ACK_EN
      tx_wr_q  <= 1'b0;
`endif
      case (state)
        WAIT_SYNC: begin
          if (tmr == BOOT_LAST) begin
            state     <= RUN;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            tmr       <= '0;
          end else if (bus.rx_done && bus.rx_data == SYNC_BYTE) begin
            state  <= LEN_H;
            tmr    <= '0;
            off_q  <= '0;
            csum_q <= '0;
          end else begin
            // Non-sync bytes deliberately leave the boot timer running.
            tmr <= tmr + TMR_W'(1);
          end
        end

        LEN_H, LEN_L, ADR_H, ADR_L, DATA, CSUM: begin
          if (tmr == BYTE_LAST) begin
            // Stalled frame: drop it silently and wait for a new sync.
            state <= WAIT_SYNC;
            tmr   <= '0;
          end else if (bus.rx_done) begin
            tmr <= '0;
            case (state)
              LEN_H: begin
                len_q[15:8] <= bus.rx_data;
                state       <= LEN_L;
              end
              LEN_L: begin
                len_q[7:0] <= bus.rx_data;
                state      <= ADR_H;
              end
              ADR_H: begin
                base_q[12:8] <= bus.rx_data[4:0];
                state        <= ADR_L;
              end
              ADR_L: begin
                base_q[7:0] <= bus.rx_data;
                state       <= (len_q == 16'd0) ? CSUM : DATA;
              end
              DATA: begin
                // 13-bit add wraps at 8 KiB; long frames overwrite earlier bytes.
                ldr_q  <= '{addr: base_q + off_q[12:0], we: 1'b1, di: bus.rx_data};
                csum_q <= csum_q + bus.rx_data;
                off_q  <= off_q + 16'd1;
                if (off_q == len_q - 16'd1) state <= CSUM;
              end
              CSUM: begin
`ifdef UART_BOOT_LOADER_ACK_EN
                tx_wr_q   <= 1'b1;
                tx_data_q <= csum_ok ? ACK_BYTE : NAK_BYTE;
                tgt_run_q <= csum_ok;
                state     <= ACK;
`else
                if (csum_ok) begin
                  state     <= RUN;
                  cpu_rst_q <= 1'b1;
                  busy_q    <= 1'b0;
                end else begin
                  state <= WAIT_SYNC;
                end
`endif
              end
              default: state <= WAIT_SYNC;
            endcase
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

`ifdef UART_BOOT_LOADER_ACK_EN
        ACK: begin
          // tmr is already 0 here, so a NAK restarts the boot timer from 0.
          if (bus.tx_done) begin
            state     <= tgt_run_q ? RUN : WAIT_SYNC;
            cpu_rst_q <= tgt_run_q;
            busy_q    <= ~tgt_run_q;
          end
        end
`endif

        RUN: begin
        end

        default: begin
          state <= WAIT_SYNC;
          tmr   <= '0;
        end
      endcase
    end
  end

  // The mux select is the registered cpu_rst, so the cpu gains the ram port on
  // the same cycle it leaves reset and never earlier.
  assign cpu_req = '{addr: bus.cpu_addr[12:0], we: bus.cpu_we, di: bus.cpu_do};
  assign ram_sel = cpu_rst_q ? cpu_req : ldr_q;

  assign bus.ram_addr = ram_sel.addr;
  assign bus.ram_we   = ram_sel.we;
  assign bus.ram_di   = ram_sel.di;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.busy     = busy_q;

  // Upper cpu address bits fall outside the 8 KiB ram.
  logic [2:0] unused_cpu_hi;
  assign unused_cpu_hi = bus.cpu_addr[15:13];

`ifdef UART_BOOT_LOADER_ACK_EN
  assign bus.tx_wr   = tx_wr_q;
  assign bus.tx_data = tx_data_q;
`else
  logic unused_tx_done;
  assign unused_tx_done = bus.tx_done;
  assign bus.tx_wr      = 1'b0;
  assign bus.tx_data    = 8'h00;
`endif
endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
  localparam int BOOT_TO = 100;
  localparam int BYTE_TO = 50;

  logic clk = 1'b0;
  logic rst;
  uart_boot_loader_if bus();

  uart_boot_loader #(
    .BOOT_TIMEOUT(BOOT_TO),
    .BYTE_TIMEOUT(BYTE_TO),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ram behind the port, plus the bench's own expectation of its contents
  logic [7:0] mem     [8192];
  logic [7:0] exp_mem [8192];
  bit         exp_valid [8192];
  int         tx_total = 0;
  int         n_run = 0;
  int         n_fail = 0;

  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
  always @(posedge clk) if (rst && bus.tx_wr) tx_total <= tx_total + 1;

  typedef struct {
    int          npre;
    logic [15:0] len;
    logic [15:0] base;
    bit          corrupt;
    int          maxgap;
    bit          exp_run;
    logic [7:0]  exp_tx;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] p [$]);
    int s = 0;
    foreach (p[i]) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  task automatic model_write(input logic [15:0] base, input int i, input logic [7:0] d);
    int a;
    a = (int'(base) + i) % 8192;
    exp_mem[a]   = d;
    exp_valid[a] = 1'b1;
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 8192; a++)
      if (exp_valid[a] && mem[a] !== exp_mem[a]) bad++;
    check(name, 64'(bad), 64'(0));
  endtask

  // One cycle; while the cpu is held, throw random cpu writes at the port
  // (they must be dropped). Called and returns at a negedge.
  task automatic step();
    if (bus.cpu_rst) bus.cpu_we = 1'b0;
    else begin
      bus.cpu_addr = 16'($urandom);
      bus.cpu_we   = 1'($urandom);
      bus.cpu_do   = 8'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
    bus.cpu_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.tx_done = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_do = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({bus.cpu_rst, bus.busy, bus.ram_we, bus.ram_addr, bus.ram_di, bus.tx_wr, bus.tx_data}),
          64'({1'b0, 1'b1, 1'b0, 13'h0, 8'h00, 1'b0, 8'h00}));
    rst = 1'b1;
  endtask

  task automatic run_frame(input logic [15:0] base, input logic [15:0] len,
                           input logic [7:0] pl [$], input logic [7:0] csum,
                           input bit exp_ok, input logic [7:0] exp_tx,
                           input int mingap, input int maxgap);
    int t0;
    t0 = tx_total;
    send_byte(8'hA5, int'($urandom_range(maxgap, mingap)));
    send_byte(len[15:8], int'($urandom_range(maxgap, mingap)));
    send_byte(len[7:0], int'($urandom_range(maxgap, mingap)));
    send_byte(base[15:8], int'($urandom_range(maxgap, mingap)));
    send_byte(base[7:0], int'($urandom_range(maxgap, mingap)));
    foreach (pl[i]) begin
      send_byte(pl[i], int'($urandom_range(maxgap, mingap)));
      model_write(base, i, pl[i]);
    end
    send_byte(csum, int'($urandom_range(maxgap, mingap)));
`ifdef UART_BOOT_LOADER_ACK_EN
    check("tx_wr_after_csum", 64'(bus.tx_wr), 64'(1));
    check("tx_data", 64'(bus.tx_data), 64'(exp_tx));
    idle(3);
    check("tx_wr_count", 64'(tx_total - t0), 64'(1));
    check("tx_data_held", 64'(bus.tx_data), 64'(exp_tx));
    check("cpu_held_until_tx_done", 64'({bus.cpu_rst, bus.busy}), 64'({1'b0, 1'b1}));
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
`else
    check("tx_idle", 64'({bus.tx_wr, bus.tx_data}), 64'(0));
    check("tx_data_unused", 64'(exp_tx & 8'h00), 64'(0));
`endif
    check("cpu_rst_after_frame", 64'(bus.cpu_rst), 64'(exp_ok));
    check("busy_after_frame", 64'(bus.busy), 64'(!exp_ok));
`ifndef UART_BOOT_LOADER_ACK_EN
    idle(3);
    check("tx_wr_count", 64'(tx_total - t0), 64'(0));
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [7:0]  q [$];
    logic [7:0]  dd [4];
    logic [7:0]  b;
    logic [7:0]  cs;
    int          first;
    int          bad;

    vecs[0] = '{2, 16'd5,    16'h0040, 1'b0, 8,  1'b1, 8'h06};
    vecs[1] = '{0, 16'd0,    16'h0000, 1'b0, 3,  1'b1, 8'h06};
    vecs[2] = '{1, 16'd1,    16'h1FFF, 1'b0, 5,  1'b1, 8'h06};
    vecs[3] = '{3, 16'd20,   16'h1FF0, 1'b0, 10, 1'b1, 8'h06};
    vecs[4] = '{0, 16'd12,   16'hE200, 1'b0, 4,  1'b1, 8'h06};
    vecs[5] = '{1, 16'd7,    16'h0300, 1'b1, 6,  1'b0, 8'h15};
    vecs[6] = '{0, 16'd8195, 16'h0800, 1'b0, 0,  1'b1, 8'h06};
    vecs[7] = '{2, 16'd33,   16'h1000, 1'b1, 9,  1'b0, 8'h15};

    // Boot timeout with no traffic: cpu released on cycle 99 after reset.
    do_reset();
    first = -1; bad = 0;
    for (int c = 0; c < 105; c++) begin
      @(negedge clk);
      if (bus.cpu_rst && first < 0) first = c;
      if (bus.busy === bus.cpu_rst) bad++;
    end
    check("boot_release_cycle", 64'(first), 64'(99));
    check("busy_tracks_cpu_rst", 64'(bad), 64'(0));
    bus.cpu_addr = 16'hE123; bus.cpu_do = 8'h5A; bus.cpu_we = 1'b1;
    #1;
    check("run_ram_mux", 64'({bus.ram_we, bus.ram_addr, bus.ram_di}),
          64'({1'b1, 13'h0123, 8'h5A}));
    @(negedge clk);
    bus.cpu_we = 1'b0;
    model_write(16'h0123, 0, 8'h5A);
    send_byte(8'hA5, 0);
    idle(5);
    check("run_ignores_rx", 64'({bus.cpu_rst, bus.busy}), 64'({1'b1, 1'b0}));
    check_ram("run_cpu_write");

    // Reference frame with leading junk bytes.
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 2);
    q.delete(); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    run_frame(16'h0100, 16'd3, q, 8'h66, 1'b1, 8'h06, 0, 2);
    check("ref_frame_ram", 64'({mem[256], mem[257], mem[258]}), 64'(24'h112233));

    // Bad checksum, then a good frame without another reset.
    do_reset();
    run_frame(16'h0100, 16'd3, q, 8'h67, 1'b0, 8'h15, 0, 2);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    run_frame(16'h0180, 16'd4, q, sum8(q), 1'b1, 8'h06, 0, 3);
    check_ram("nak_then_ack_ram");

    // Address wrap, with inter-byte gaps one short of the byte timeout.
    do_reset();
    q.delete(); q.push_back(8'hAA); q.push_back(8'hBB);
    run_frame(16'h1FFF, 16'd2, q, 8'h65, 1'b1, 8'h06, 48, 48);
    check("wrap_ram", 64'({mem[8191], mem[0]}), 64'(16'hAABB));

    // Frame stalls after the length: back to WAIT_SYNC after 50 idle cycles,
    // visible as the boot timer restarting from that point.
    do_reset();
    first = tx_total;
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    bad = first;
    first = -1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (bus.cpu_rst && first < 0) first = k;
    end
    check("byte_timeout_release", 64'(first), 64'(150));
    check("byte_timeout_no_tx", 64'(tx_total - bad), 64'(0));

    // Write timing inside DATA, then reset mid-frame.
    do_reset();
    send_byte(8'hA5, 1);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
    send_byte(dd[0], 0);
    check("data_write_next_cycle", 64'({bus.ram_we, bus.ram_addr, bus.ram_di}),
          64'({1'b1, 13'h0400, dd[0]}));
    model_write(16'h0400, 0, dd[0]);
    idle(1);
    check("data_write_one_cycle", 64'(bus.ram_we), 64'(0));
    for (int i = 1; i < 4; i++) send_byte(dd[i], 0);
    model_write(16'h0400, 1, dd[1]);
    model_write(16'h0400, 2, dd[2]);
    check("data_write_offset3", 64'({bus.ram_we, bus.ram_addr, bus.ram_di}),
          64'({1'b1, 13'h0403, dd[3]}));
    rst = 1'b0;
    #1;
    check("rst_mid_data", 64'({bus.cpu_rst, bus.busy, bus.ram_we, bus.ram_addr}),
          64'({1'b0, 1'b1, 1'b0, 13'h0}));
    @(negedge clk);
    rst = 1'b1;
    check_ram("rst_partial_ram");

    // Table of randomized frames.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int p = 0; p < vecs[v].npre; p++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b, int'($urandom_range(5, 0)));
      end
      q.delete();
      for (int i = 0; i < int'(vecs[v].len); i++) q.push_back(8'($urandom));
      cs = sum8(q);
      if (vecs[v].corrupt) cs = cs + 8'd1;
      run_frame(vecs[v].base, vecs[v].len, q, cs, vecs[v].exp_run, vecs[v].exp_tx,
                0, vecs[v].maxgap);
      check_ram($sformatf("vec%0d_ram", v));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
